// File: rtl/store_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_align_unit
// Description : Store-data alignment and split unit. Aligns LSB-justified
//               store data onto memory byte lanes, generates the byte write
//               mask, and splits word-boundary-crossing stores into two beats
//               (or traps them when misaligned stores are disallowed).
// Revision    : 1.0 - initial release
// ============================================================================
module store_align_unit #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [XLEN-1:0]   req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic              misalign_fault,
    output logic              busy
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int MW    = 2 * NB;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BEAT_LAST  = 2'd1,
        BEAT_FIRST = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n, hi_addr, hi_addr_n;
    logic [XLEN-1:0]   wdata_n, hi_wdata, hi_wdata_n;
    logic [NB-1:0]     wmask_n, hi_wmask, hi_wmask_n;
    logic              fault_n;

    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  size_low_mask;
    logic [MW-1:0]     base_mask, wide_mask;
    logic [2*XLEN-1:0] base_data, wide_data;
    logic [ADDR_W-1:0] aligned_addr;
    logic              illegal_size, misaligned, accept;

    assign off          = req_addr[OFF_W-1:0];
    assign aligned_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign illegal_size = (XLEN == 32) && (req_size == 2'b11);
    assign req_ready    = (state == IDLE) || ((state == BEAT_LAST) && mem_ready);
    assign accept       = req_valid && req_ready;
    assign mem_valid    = (state != IDLE);
    assign busy         = (state != IDLE);

    // Size decode: unshifted byte mask and natural-alignment offset mask.
    always_comb begin
        base_mask     = '0;
        size_low_mask = '0;
        case (req_size)
            2'b00: begin base_mask = MW'(8'h01); size_low_mask = '0;            end
            2'b01: begin base_mask = MW'(8'h03); size_low_mask = OFF_W'(3'd1);  end
            2'b10: begin base_mask = MW'(8'h0F); size_low_mask = OFF_W'(3'd3);  end
            default: begin base_mask = MW'(8'hFF); size_low_mask = OFF_W'(3'd7); end
        endcase
    end

    assign misaligned = !ALLOW_MISALIGNED && (|(off & size_low_mask));

    // Keep only the active store bytes so unused lanes are driven zero.
    always_comb begin
        base_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (base_mask[i]) base_data[8*i +: 8] = req_data[8*i +: 8];
        end
    end

    assign wide_mask = base_mask << off;
    assign wide_data = base_data << {off, 3'b000};

    // Next-state and next-output decode for the beat sequencer.
    always_comb begin
        state_n    = state;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        wmask_n    = mem_wmask;
        hi_addr_n  = hi_addr;
        hi_wdata_n = hi_wdata;
        hi_wmask_n = hi_wmask;
        fault_n    = 1'b0;

        if (state == BEAT_FIRST) begin
            if (mem_ready) begin
                addr_n  = hi_addr;
                wdata_n = hi_wdata;
                wmask_n = hi_wmask;
                state_n = BEAT_LAST;
            end
        end else begin
            if ((state == BEAT_LAST) && mem_ready) state_n = IDLE;
            if (accept) begin
                if (illegal_size || misaligned) begin
                    fault_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    addr_n     = aligned_addr;
                    wdata_n    = wide_data[XLEN-1:0];
                    wmask_n    = wide_mask[NB-1:0];
                    hi_addr_n  = aligned_addr + ADDR_W'(NB);
                    hi_wdata_n = wide_data[2*XLEN-1:XLEN];
                    hi_wmask_n = wide_mask[MW-1:NB];
                    state_n    = (|wide_mask[MW-1:NB]) ? BEAT_FIRST : BEAT_LAST;
                end
            end
        end
    end

    // State and output registers; reset discards any pending beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            hi_addr        <= '0;
            hi_wdata       <= '0;
            hi_wmask       <= '0;
            misalign_fault <= 1'b0;
        end else begin
            state          <= state_n;
            mem_addr       <= addr_n;
            mem_wdata      <= wdata_n;
            mem_wmask      <= wmask_n;
            hi_addr        <= hi_addr_n;
            hi_wdata       <= hi_wdata_n;
            hi_wmask       <= hi_wmask_n;
            misalign_fault <= fault_n;
        end
    end

endmodule
`default_nettype wire
